// File: rtl/knn_scan_controller.sv
// k-NN scan sequencer: captures a test vector, replays it to the distance engine
// for every stored sample, keeps the K nearest distances and votes on their labels.
module knn_scan_controller #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_FEATURES = 8,
    parameter int NUM_SAMPLES  = 16,
    parameter int K            = 3,
    parameter int LABEL_WIDTH  = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int IDX_WIDTH    = 4,
    parameter int TIMEOUT      = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    input  logic [DATA_WIDTH-1:0]     test_in_data,
    input  logic                      test_in_valid,
    output logic                      test_in_ready,
    output logic                      eng_en,
    output logic                      eng_start,
    output logic [ADDR_WIDTH-1:0]     eng_base,
    output logic [DATA_WIDTH-1:0]     eng_feat,
    output logic                      eng_feat_valid,
    input  logic                      eng_done,
    input  logic [2*DATA_WIDTH-1:0]   eng_distance,
    output logic [IDX_WIDTH-1:0]      label_addr,
    input  logic [LABEL_WIDTH-1:0]    label_data,
    output logic                      result_valid,
    output logic [LABEL_WIDTH-1:0]    result_label,
    output logic [IDX_WIDTH-1:0]      result_index,
    output logic [2*DATA_WIDTH-1:0]   result_distance
);
    localparam int DW = 2 * DATA_WIDTH;
    localparam int FW = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam int RW = (K > 1) ? $clog2(K) : 1;
    localparam int CW = $clog2(K + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, LOAD_TEST, ISSUE, STREAM, WAIT_ENG, INSERT, LBL_ADDR, LBL_CAP, VOTE, FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  buf_q [NUM_FEATURES];
    logic [DATA_WIDTH-1:0]  buf_d [NUM_FEATURES];
    logic [FW-1:0]          feat_q, feat_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic [RW-1:0]          rank_q, rank_d;
    logic [DW-1:0]          dist_q, dist_d;
    logic [DW-1:0]          ent_dist_q [K];
    logic [DW-1:0]          ent_dist_d [K];
    logic [IDX_WIDTH-1:0]   ent_idx_q [K];
    logic [IDX_WIDTH-1:0]   ent_idx_d [K];
    logic [LABEL_WIDTH-1:0] ent_lbl_q [K];
    logic [LABEL_WIDTH-1:0] ent_lbl_d [K];
    logic [K-1:0]           ent_vld_q, ent_vld_d;
    logic [CW-1:0]          best_cnt_q, best_cnt_d;
    logic [LABEL_WIDTH-1:0] best_lbl_q, best_lbl_d;
    logic                   error_q, error_d;
    logic                   result_valid_q, result_valid_d;
    logic [LABEL_WIDTH-1:0] result_label_q, result_label_d;
    logic [IDX_WIDTH-1:0]   result_index_q, result_index_d;
    logic [DW-1:0]          result_distance_q, result_distance_d;
    int                     pos;
    int                     cnt;
    logic                   take;

    always_comb begin
        state_d           = state_q;
        buf_d             = buf_q;
        feat_d            = feat_q;
        idx_d             = idx_q;
        wd_d              = wd_q;
        rank_d            = rank_q;
        dist_d            = dist_q;
        ent_dist_d        = ent_dist_q;
        ent_idx_d         = ent_idx_q;
        ent_lbl_d         = ent_lbl_q;
        ent_vld_d         = ent_vld_q;
        best_cnt_d        = best_cnt_q;
        best_lbl_d        = best_lbl_q;
        error_d           = error_q;
        result_valid_d    = result_valid_q;
        result_label_d    = result_label_q;
        result_index_d    = result_index_q;
        result_distance_d = result_distance_q;
        pos               = 0;
        cnt               = 0;
        take              = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ent_vld_d      = '0;
                    result_valid_d = 1'b0;
                    error_d        = 1'b0;
                    idx_d          = '0;
                    feat_d         = '0;
                    state_d        = LOAD_TEST;
                end
            end
            LOAD_TEST: begin
                if (test_in_valid) begin
                    buf_d[feat_q] = test_in_data;
                    if (feat_q == FW'(NUM_FEATURES - 1)) begin
                        feat_d  = '0;
                        state_d = ISSUE;
                    end else begin
                        feat_d = feat_q + FW'(1);
                    end
                end
            end
            ISSUE: begin
                feat_d  = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (feat_q == FW'(NUM_FEATURES - 1)) begin
                    wd_d    = '0;
                    state_d = WAIT_ENG;
                end else begin
                    feat_d = feat_q + FW'(1);
                end
            end
            WAIT_ENG: begin
                if (eng_done) begin
                    dist_d  = eng_distance;
                    state_d = INSERT;
                end else if (wd_q == WW'(TIMEOUT)) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            INSERT: begin
                // Counting ties as "ahead" keeps earlier samples in front on equal distance.
                for (int j = 0; j < K; j++) begin
                    if (ent_vld_q[j] && (ent_dist_q[j] <= dist_q)) pos = pos + 1;
                end
                for (int j = K - 1; j > 0; j--) begin
                    if (j > pos) begin
                        ent_dist_d[j] = ent_dist_q[j-1];
                        ent_idx_d[j]  = ent_idx_q[j-1];
                        ent_vld_d[j]  = ent_vld_q[j-1];
                    end
                end
                if (pos < K) begin
                    ent_dist_d[pos] = dist_q;
                    ent_idx_d[pos]  = idx_q;
                    ent_vld_d[pos]  = 1'b1;
                end
                if (idx_q == IDX_WIDTH'(NUM_SAMPLES - 1)) begin
                    rank_d  = '0;
                    state_d = LBL_ADDR;
                end else begin
                    idx_d   = idx_q + IDX_WIDTH'(1);
                    state_d = ISSUE;
                end
            end
            LBL_ADDR: state_d = LBL_CAP;
            LBL_CAP: begin
                ent_lbl_d[rank_q] = label_data;
                if (rank_q == RW'(K - 1)) begin
                    rank_d     = '0;
                    best_cnt_d = '0;
                    state_d    = VOTE;
                end else begin
                    rank_d  = rank_q + RW'(1);
                    state_d = LBL_ADDR;
                end
            end
            VOTE: begin
                for (int j = 0; j < K; j++) begin
                    if (ent_vld_q[j] && (ent_lbl_q[j] == ent_lbl_q[rank_q])) cnt = cnt + 1;
                end
                take = (cnt > int'(best_cnt_q));
                if (take) begin
                    best_cnt_d = CW'(cnt);
                    best_lbl_d = ent_lbl_q[rank_q];
                end
                // Results are loaded here so they are already valid alongside done.
                if (rank_q == RW'(K - 1)) begin
                    result_valid_d    = 1'b1;
                    result_label_d    = take ? ent_lbl_q[rank_q] : best_lbl_q;
                    result_index_d    = ent_idx_q[0];
                    result_distance_d = ent_dist_q[0];
                    state_d           = FINISH;
                end else begin
                    rank_d = rank_q + RW'(1);
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            feat_q            <= '0;
            idx_q             <= '0;
            wd_q              <= '0;
            rank_q            <= '0;
            dist_q            <= '0;
            ent_dist_q        <= '{default: '0};
            ent_idx_q         <= '{default: '0};
            ent_lbl_q         <= '{default: '0};
            ent_vld_q         <= '0;
            best_cnt_q        <= '0;
            best_lbl_q        <= '0;
            error_q           <= 1'b0;
            result_valid_q    <= 1'b0;
            result_label_q    <= '0;
            result_index_q    <= '0;
            result_distance_q <= '0;
        end else begin
            state_q           <= state_d;
            feat_q            <= feat_d;
            idx_q             <= idx_d;
            wd_q              <= wd_d;
            rank_q            <= rank_d;
            dist_q            <= dist_d;
            ent_dist_q        <= ent_dist_d;
            ent_idx_q         <= ent_idx_d;
            ent_lbl_q         <= ent_lbl_d;
            ent_vld_q         <= ent_vld_d;
            best_cnt_q        <= best_cnt_d;
            best_lbl_q        <= best_lbl_d;
            error_q           <= error_d;
            result_valid_q    <= result_valid_d;
            result_label_q    <= result_label_d;
            result_index_q    <= result_index_d;
            result_distance_q <= result_distance_d;
        end
    end

    assign busy            = (state_q != IDLE) && (state_q != FINISH);
    assign done            = (state_q == FINISH);
    assign error           = error_q;
    assign test_in_ready   = (state_q == LOAD_TEST);
    assign eng_en          = busy;
    assign eng_start       = (state_q == ISSUE);
    assign eng_base        = ADDR_WIDTH'(int'(idx_q) * NUM_FEATURES);
    assign eng_feat        = (state_q == STREAM) ? buf_q[feat_q] : '0;
    assign eng_feat_valid  = (state_q == STREAM);
    assign label_addr      = (state_q == LBL_ADDR) ? ent_idx_q[rank_q] : '0;
    assign result_valid    = result_valid_q;
    assign result_label    = result_label_q;
    assign result_index    = result_index_q;
    assign result_distance = result_distance_q;
endmodule

// File: doc/knn_scan_controller.md
# knn_scan_controller

Sequencer for the k-NN classifier. It captures one test vector from the host and runs the distance engine once per stored sample, replaying the test vector to the engine on every run. It keeps a sorted list of the K smallest distances, fetches their class labels, and issues a majority-vote classification. It sits between the host/feature front end and the distance engine, and owns the engine's start, feature and enable lines.

## Interface
- DATA_WIDTH, 16: feature width; distances are 2*DATA_WIDTH, unsigned.
- NUM_FEATURES, 8: features per vector.
- NUM_SAMPLES, 16: stored samples scanned per classification.
- K, 3: neighbours kept. Legal range is 1..NUM_SAMPLES.
- LABEL_WIDTH, 4: class label width.
- ADDR_WIDTH, 8: sample-memory address width.
- IDX_WIDTH, 4: sample index width, ≥ clog2(NUM_SAMPLES).
- TIMEOUT, 1024: maximum cycles to wait for eng_done.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to classify. Ignored while busy.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  engine timeout on the last run; held until the next accepted start.
- test_in_data  in  DATA_WIDTH  host test feature.
- test_in_valid  in  1  host feature valid.
- test_in_ready  out  1  high only in LOAD_TEST; a feature transfers when valid & ready.
- eng_en  out  1  engine enable; high while busy.
- eng_start  out  1  one-cycle engine start pulse.
- eng_base  out  ADDR_WIDTH  base address of the current sample = idx*NUM_FEATURES; stable for the whole run.
- eng_feat  out  DATA_WIDTH  replayed test feature.
- eng_feat_valid  out  1  eng_feat valid.
- eng_done  in  1  engine completion pulse.
- eng_distance  in  2*DATA_WIDTH  valid in the cycle eng_done is high.
- label_addr  out  IDX_WIDTH  label RAM address; the RAM is synchronous with 1-cycle latency.
- label_data  in  LABEL_WIDTH  label RAM data.
- result_valid  out  1  results valid; level signal, cleared on the next accepted start.
- result_label  out  LABEL_WIDTH  voted class.
- result_index  out  IDX_WIDTH  index of the nearest sample.
- result_distance  out  2*DATA_WIDTH  distance of the nearest sample.

## Operation
- States: IDLE, LOAD_TEST, ISSUE, STREAM, WAIT_ENG, INSERT, LBL_ADDR, LBL_CAP, VOTE, FINISH.
- IDLE:
  - On start, clear the top-K list (all entries invalid), result_valid and error, set idx=0, and go to LOAD_TEST.
- LOAD_TEST:
  - Store transferred features into the local buffer [0..NUM_FEATURES-1] in order.
  - Host gaps stall the state.
  - After the NUM_FEATURES-th transfer, go to ISSUE.
- ISSUE:
  - eng_start=1 for one cycle and eng_base=idx*NUM_FEATURES, then go to STREAM.
- STREAM:
  - Drive eng_feat=buffer[f] with eng_feat_valid=1 for f=0..NUM_FEATURES-1, one per cycle with no gaps.
  - Then go to WAIT_ENG.
- WAIT_ENG:
  - On eng_done, capture eng_distance and go to INSERT.
  - A watchdog counter starts at 0 on entry. When it reaches TIMEOUT, set error=1 and go to FINISH with result_valid staying 0.
- INSERT:
  - pos = number of valid entries with distance ≤ new distance. On equal distance, the earlier sample ranks ahead.
  - If pos<K: shift entries pos..K-2 down one rank, write {distance, idx} at pos, and mark it valid. If pos=K, the new sample is dropped.
  - If idx=NUM_SAMPLES-1, go to LBL_ADDR with rank r=0. Otherwise increment idx and go to ISSUE.
- LBL_ADDR / LBL_CAP:
  - LBL_ADDR drives label_addr=entry[r].index.
  - LBL_CAP captures label_data into entry[r].label.
  - Repeat for r=0..K-1, then go to VOTE.
- VOTE:
  - One rank per cycle, r=0..K-1.
  - count = number of entries whose label equals entry[r].label; the K comparisons are done in parallel.
  - Replace the best candidate only on strictly greater count, so on ties the nearest rank wins.
  - Then go to FINISH.
- FINISH:
  - done=1 and busy drops.
  - If error=0: result_valid=1, result_label=winner, result_index=entry[0].index, result_distance=entry[0].distance.
  - Go to IDLE.
- Arithmetic:
  - Distance compares are unsigned over 2*DATA_WIDTH.
  - eng_base is the product idx*NUM_FEATURES truncated to ADDR_WIDTH. Sizing so it does not wrap is the integrator's responsibility.

## Timing
- Reset values: all outputs 0. The list is invalid, state is IDLE, and the buffer is not cleared.
- Reset mid-operation aborts immediately. No done pulse is issued.
- start→busy takes 1 cycle.
- Per-sample cost is 1 (ISSUE) + NUM_FEATURES (STREAM) + engine latency + 1 (INSERT).
- The first eng_feat_valid occurs the cycle after eng_start, which matches the engine's load step.
- Tail cost is 2K (labels) + K (vote) + 1 (FINISH) cycles.
- An eng_done outside WAIT_ENG is ignored.
- start during busy, including start coincident with done, is ignored.
- result_* hold their value until the next accepted start.

## Test plan
- Nearest set: K=3, the bench engine returns 100-5*idx and labels are 15→2, 14→2, 13→5, others→7. Required: result_label=2, result_index=15, result_distance=25, done is exactly one pulse, error=0.
- Ties: every distance is 7 and labels for idx 0, 1, 2 are 1, 2, 3. Required: the list holds idx 0, 1, 2; result_label=1, result_index=0.
- Replay: the host sends features 0x0011..0x0018 with random valid gaps. Required: every run shows eng_feat 0x0011..0x0018 on consecutive cycles, eng_base=idx*8, and 16 eng_start pulses.
- Timeout: the engine never raises done on sample 4. Required: after TIMEOUT cycles in WAIT_ENG, done=1, error=1, result_valid=0, busy=0; a following start clears error.
- Control hazards: start is pulsed mid-scan, an eng_done is injected while in STREAM, and rst_n is asserted mid-INSERT. Required: the mid-scan start and the stray eng_done have no effect; reset returns all outputs to 0; a subsequent full run matches the nearest-set expected result.
